// File: rtl/alu_busy_tracker_pkg.sv
// Shared constants and types for the issue-side busy tracker:
// default busy lengths, LSU credit depth, counter widths and SALU states.
package alu_busy_tracker_pkg;

    // Width of each per-ALU busy down-counter (holds 0..15).
    localparam int unsigned BUSY_CNT_W = 4;

    // Width of the LSU free-credit counter (holds 0..7).
    localparam int unsigned CREDIT_W = 3;

    // Default number of cycles a SIMD ALU stays busy after an issue.
    localparam int unsigned DEF_SIMD_BUSY_CYCLES = 4;

    // Default number of cycles a SIMF ALU stays busy after an issue.
    localparam int unsigned DEF_SIMF_BUSY_CYCLES = 8;

    // Default LSU outstanding-issue capacity.
    localparam int unsigned DEF_LSU_CREDITS = 4;

    // Number of SIMD and of SIMF ALUs tracked.
    localparam int unsigned NUM_SIMD = 4;
    localparam int unsigned NUM_SIMF = 4;

    // SALU occupancy states.
    typedef enum logic {
        SALU_IDLE = 1'b0,
        SALU_BUSY = 1'b1
    } salu_state_e;

    // True when an LSU credit update would underflow (issue with no credit
    // left and no retire in the same cycle).
    function automatic logic lsu_underflow(input logic             sel,
                                           input logic             done,
                                           input logic [CREDIT_W-1:0] credits);
        return sel && !done && (credits == '0);
    endfunction

    // True when an LSU credit update would overflow (retire with every
    // credit already free and no issue in the same cycle).
    function automatic logic lsu_overflow(input logic              sel,
                                          input logic              done,
                                          input logic [CREDIT_W-1:0] credits,
                                          input logic [CREDIT_W-1:0] max_credits);
        return done && !sel && (credits == max_credits);
    endfunction

endpackage

// File: rtl/alu_busy_counter.sv
// Busy tracker for one pipelined ALU: loads BUSY_CYCLES when issued while
// idle, then counts down to zero. The unit is ready only at zero.
module alu_busy_counter
    import alu_busy_tracker_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES = DEF_SIMD_BUSY_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic select,
    output logic ready,
    output logic violation
);

    logic [BUSY_CNT_W-1:0] busy_cnt;
    logic                  idle;

    assign idle = (busy_cnt == '0);

    // Load on an accepted issue, otherwise count down and hold at zero.
    // An issue while busy does not restart the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt <= '0;
        end else if (select && idle) begin
            busy_cnt <= BUSY_CNT_W'(BUSY_CYCLES);
        end else if (!idle) begin
            busy_cnt <= busy_cnt - BUSY_CNT_W'(1);
        end
    end

    // Ready comes straight from the register so reset clears it at once.
    assign ready     = idle;

    // An issue that lands while the unit is still busy is illegal.
    assign violation = select && !idle;

endmodule

// File: rtl/alu_busy_tracker.sv
// Issue-side occupancy tracker for four SIMD ALUs, four SIMF ALUs, the LSU
// (credit based) and the SALU (idle/busy handshake). Any issue to a unit
// that is not ready, or any credit overflow, sets a sticky violation flag.
//
// Handshake: a *_select pulse is an issue into that unit on the rising edge
// where it is high; the issuer may only do so while the matching *_ready is
// high in that same cycle. lsu_done / salu_done are completion pulses from
// the unit and are not gated by any ready.
module alu_busy_tracker
    import alu_busy_tracker_pkg::*;
#(
    parameter int unsigned SIMD_BUSY_CYCLES = DEF_SIMD_BUSY_CYCLES,
    parameter int unsigned SIMF_BUSY_CYCLES = DEF_SIMF_BUSY_CYCLES,
    parameter int unsigned LSU_CREDITS      = DEF_LSU_CREDITS
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                simd0_alu_select,
    input  logic                simd1_alu_select,
    input  logic                simd2_alu_select,
    input  logic                simd3_alu_select,
    input  logic                simf0_alu_select,
    input  logic                simf1_alu_select,
    input  logic                simf2_alu_select,
    input  logic                simf3_alu_select,

    input  logic                lsu_lsu_select,
    input  logic                lsu_done,
    input  logic                salu_alu_select,
    input  logic                salu_done,

    output logic                simd0_alu_ready,
    output logic                simd1_alu_ready,
    output logic                simd2_alu_ready,
    output logic                simd3_alu_ready,
    output logic                simf0_alu_ready,
    output logic                simf1_alu_ready,
    output logic                simf2_alu_ready,
    output logic                simf3_alu_ready,

    output logic                lsu_ready,
    output logic                salu_alu_ready,
    output logic [CREDIT_W-1:0] lsu_credit_cnt,
    output logic                issue_violation,

    // Current SALU state (1 = BUSY), for observation only.
    output logic                salu_state_dbg
);

    localparam logic [CREDIT_W-1:0] MAX_CREDITS = CREDIT_W'(LSU_CREDITS);

    logic [NUM_SIMD-1:0] simd_sel;
    logic [NUM_SIMD-1:0] simd_rdy;
    logic [NUM_SIMD-1:0] simd_viol;
    logic [NUM_SIMF-1:0] simf_sel;
    logic [NUM_SIMF-1:0] simf_rdy;
    logic [NUM_SIMF-1:0] simf_viol;

    logic                lsu_viol;
    logic                salu_viol;
    logic                any_viol;

    salu_state_e         salu_state;
    logic                salu_ready_q;

    assign simd_sel = {simd3_alu_select, simd2_alu_select,
                       simd1_alu_select, simd0_alu_select};
    assign simf_sel = {simf3_alu_select, simf2_alu_select,
                       simf1_alu_select, simf0_alu_select};

    // ------------------------------------------------------------------
    // SIMD / SIMF busy counters, one per ALU.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < int'(NUM_SIMD); i++) begin : g_simd
        alu_busy_counter #(
            .BUSY_CYCLES (SIMD_BUSY_CYCLES)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .select    (simd_sel[i]),
            .ready     (simd_rdy[i]),
            .violation (simd_viol[i])
        );
    end

    for (genvar i = 0; i < int'(NUM_SIMF); i++) begin : g_simf
        alu_busy_counter #(
            .BUSY_CYCLES (SIMF_BUSY_CYCLES)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .select    (simf_sel[i]),
            .ready     (simf_rdy[i]),
            .violation (simf_viol[i])
        );
    end

    assign simd0_alu_ready = simd_rdy[0];
    assign simd1_alu_ready = simd_rdy[1];
    assign simd2_alu_ready = simd_rdy[2];
    assign simd3_alu_ready = simd_rdy[3];
    assign simf0_alu_ready = simf_rdy[0];
    assign simf1_alu_ready = simf_rdy[1];
    assign simf2_alu_ready = simf_rdy[2];
    assign simf3_alu_ready = simf_rdy[3];

    // ------------------------------------------------------------------
    // LSU credits: an issue takes one, a retire gives one back, both in
    // the same cycle cancel. Out-of-range updates are dropped and flagged.
    // ------------------------------------------------------------------
    assign lsu_viol = lsu_underflow(lsu_lsu_select, lsu_done, lsu_credit_cnt)
                    | lsu_overflow(lsu_lsu_select, lsu_done, lsu_credit_cnt,
                                   MAX_CREDITS);

    // Track free LSU credits, saturating at 0 and at the full count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lsu_credit_cnt <= MAX_CREDITS;
        end else begin
            unique case ({lsu_lsu_select, lsu_done})
                2'b10: begin
                    if (lsu_credit_cnt != '0) begin
                        lsu_credit_cnt <= lsu_credit_cnt - CREDIT_W'(1);
                    end
                end
                2'b01: begin
                    if (lsu_credit_cnt != MAX_CREDITS) begin
                        lsu_credit_cnt <= lsu_credit_cnt + CREDIT_W'(1);
                    end
                end
                default: begin
                    lsu_credit_cnt <= lsu_credit_cnt;
                end
            endcase
        end
    end

    assign lsu_ready = (lsu_credit_cnt != '0);

    // ------------------------------------------------------------------
    // SALU: single outstanding instruction. Done has priority over a
    // simultaneous select, which is still flagged as illegal.
    // ------------------------------------------------------------------
    assign salu_viol = salu_alu_select && (salu_state == SALU_BUSY);

    // SALU state machine with its ready output registered alongside.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            salu_state   <= SALU_IDLE;
            salu_ready_q <= 1'b1;
        end else begin
            unique case (salu_state)
                SALU_IDLE: begin
                    if (salu_alu_select) begin
                        salu_state   <= SALU_BUSY;
                        salu_ready_q <= 1'b0;
                    end
                end
                SALU_BUSY: begin
                    if (salu_done) begin
                        salu_state   <= SALU_IDLE;
                        salu_ready_q <= 1'b1;
                    end
                end
                default: begin
                    salu_state   <= SALU_IDLE;
                    salu_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign salu_alu_ready = salu_ready_q;
    assign salu_state_dbg = (salu_state == SALU_BUSY);

    // ------------------------------------------------------------------
    // Sticky violation flag.
    // ------------------------------------------------------------------
    assign any_viol = (|simd_viol) | (|simf_viol) | lsu_viol | salu_viol;

    // Latch any violation until the next reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_violation <= 1'b0;
        end else if (any_viol) begin
            issue_violation <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_busy_tracker.sv
// Self-checking bench for alu_busy_tracker: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural occupancy model.
module tb_alu_busy_tracker;

    localparam int SIMD_N = 4;
    localparam int SIMF_N = 8;
    localparam int CRED_N = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [3:0] simd_sel;
    logic [3:0] simf_sel;
    logic       lsu_sel;
    logic       lsu_done;
    logic       salu_sel;
    logic       salu_done;

    wire [3:0]  simd_rdy;
    wire [3:0]  simf_rdy;
    wire        lsu_ready;
    wire        salu_alu_ready;
    wire [2:0]  lsu_credit_cnt;
    wire        issue_violation;
    wire        salu_state_dbg;

    alu_busy_tracker dut (
        .clk              (clk),
        .rst              (rst),
        .simd0_alu_select (simd_sel[0]),
        .simd1_alu_select (simd_sel[1]),
        .simd2_alu_select (simd_sel[2]),
        .simd3_alu_select (simd_sel[3]),
        .simf0_alu_select (simf_sel[0]),
        .simf1_alu_select (simf_sel[1]),
        .simf2_alu_select (simf_sel[2]),
        .simf3_alu_select (simf_sel[3]),
        .lsu_lsu_select   (lsu_sel),
        .lsu_done         (lsu_done),
        .salu_alu_select  (salu_sel),
        .salu_done        (salu_done),
        .simd0_alu_ready  (simd_rdy[0]),
        .simd1_alu_ready  (simd_rdy[1]),
        .simd2_alu_ready  (simd_rdy[2]),
        .simd3_alu_ready  (simd_rdy[3]),
        .simf0_alu_ready  (simf_rdy[0]),
        .simf1_alu_ready  (simf_rdy[1]),
        .simf2_alu_ready  (simf_rdy[2]),
        .simf3_alu_ready  (simf_rdy[3]),
        .lsu_ready        (lsu_ready),
        .salu_alu_ready   (salu_alu_ready),
        .lsu_credit_cnt   (lsu_credit_cnt),
        .issue_violation  (issue_violation),
        .salu_state_dbg   (salu_state_dbg)
    );

    // ---------------- behavioural model ----------------
    // Remaining busy cycles per ALU, free LSU credits, SALU occupancy and
    // the sticky violation flag.
    int simd_left[4];
    int simf_left[4];
    int credits;
    bit salu_busy_m;
    bit viol_m;

    int vectors = 0;
    int errors  = 0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            simd_left[i] = 0;
            simf_left[i] = 0;
        end
        credits     = CRED_N;
        salu_busy_m = 1'b0;
        viol_m      = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            if (simd_sel[i] && simd_left[i] == 0) simd_left[i] = SIMD_N;
            else begin
                if (simd_sel[i]) viol_m = 1'b1;
                if (simd_left[i] > 0) simd_left[i] = simd_left[i] - 1;
            end
            if (simf_sel[i] && simf_left[i] == 0) simf_left[i] = SIMF_N;
            else begin
                if (simf_sel[i]) viol_m = 1'b1;
                if (simf_left[i] > 0) simf_left[i] = simf_left[i] - 1;
            end
        end
        if (lsu_sel && !lsu_done) begin
            if (credits == 0) viol_m = 1'b1;
            else credits = credits - 1;
        end else if (lsu_done && !lsu_sel) begin
            if (credits == CRED_N) viol_m = 1'b1;
            else credits = credits + 1;
        end
        if (salu_busy_m) begin
            if (salu_sel) viol_m = 1'b1;
            if (salu_done) salu_busy_m = 1'b0;
        end else if (salu_sel) begin
            salu_busy_m = 1'b1;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic check_all(input string tag);
        logic [3:0] e_simd;
        logic [3:0] e_simf;
        for (int i = 0; i < 4; i++) begin
            e_simd[i] = (simd_left[i] == 0);
            e_simf[i] = (simf_left[i] == 0);
        end
        check({tag, ".simd_ready"}, 32'(simd_rdy), 32'(e_simd));
        check({tag, ".simf_ready"}, 32'(simf_rdy), 32'(e_simf));
        check({tag, ".lsu_credits"}, 32'(lsu_credit_cnt), 32'(credits));
        check({tag, ".lsu_ready"}, 32'(lsu_ready), 32'(credits != 0));
        check({tag, ".salu_ready"}, 32'(salu_alu_ready), 32'(!salu_busy_m));
        check({tag, ".salu_state"}, 32'(salu_state_dbg), 32'(salu_busy_m));
        check({tag, ".violation"}, 32'(issue_violation), 32'(viol_m));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        simd_sel  = '0;
        simf_sel  = '0;
        lsu_sel   = 1'b0;
        lsu_done  = 1'b0;
        salu_sel  = 1'b0;
        salu_done = 1'b0;
    endtask

    // Called at a falling edge with inputs already set: clock once, update
    // the model, compare at the next falling edge, then drop the pulses.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
        drive_idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        model_reset();
        #1;
        check_all("in_reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive_idle();
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset_hold");
        check("reset_ready_lit", 32'({simf_rdy, simd_rdy, lsu_ready, salu_alu_ready}), 32'h3FF);
        check("reset_credit_lit", 32'(lsu_credit_cnt), 32'd4);
        rst = 1'b1;

        // Idle after reset release.
        repeat (3) tick("idle");
        check("idle_ready_lit", 32'({simf_rdy, simd_rdy, lsu_ready, salu_alu_ready}), 32'h3FF);
        check("idle_credit_lit", 32'(lsu_credit_cnt), 32'd4);
        check("idle_viol_lit", 32'(issue_violation), 32'd0);

        // simd2: busy for 4 cycles, others untouched.
        simd_sel[2] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick("simd2");
            check("simd2_ready_lit", 32'(simd_rdy[2]), 32'(k == 5));
            check("simd_others_lit", 32'({simd_rdy[3], simd_rdy[1:0], simf_rdy}), 32'h7F);
        end
        check("model_simd2_pin", 32'(simd_left[2]), 32'd0);

        // simf0: reselect while busy flags violation, count not restarted.
        do_reset();
        simf_sel[0] = 1'b1;
        tick("simf0_a");
        check("model_simf0_pin", 32'(simf_left[0]), 32'd8);
        tick("simf0_b");
        check("simf0_viol_early_lit", 32'(issue_violation), 32'd0);
        simf_sel[0] = 1'b1;
        tick("simf0_c");
        check("simf0_viol_lit", 32'(issue_violation), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            tick("simf0_d");
            check("simf0_ready_lit", 32'(simf_rdy[0]), 32'(k == 6));
        end

        // LSU credits: drain, select+done at zero, then underflow.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            lsu_sel = 1'b1;
            tick("lsu_drain");
            check("lsu_credit_lit", 32'(lsu_credit_cnt), 32'(4 - k));
        end
        check("lsu_ready_zero_lit", 32'(lsu_ready), 32'd0);
        lsu_sel = 1'b1; lsu_done = 1'b1;
        tick("lsu_both");
        check("lsu_both_credit_lit", 32'(lsu_credit_cnt), 32'd0);
        check("lsu_both_viol_lit", 32'(issue_violation), 32'd0);
        lsu_sel = 1'b1;
        tick("lsu_under");
        check("lsu_under_viol_lit", 32'(issue_violation), 32'd1);
        check("lsu_under_credit_lit", 32'(lsu_credit_cnt), 32'd0);

        // LSU overflow at full credits.
        do_reset();
        lsu_done = 1'b1;
        tick("lsu_over");
        check("lsu_over_viol_lit", 32'(issue_violation), 32'd1);
        check("lsu_over_credit_lit", 32'(lsu_credit_cnt), 32'd4);

        // SALU: done in IDLE is ignored.
        do_reset();
        salu_done = 1'b1;
        tick("salu_idle_done");
        check("salu_idle_done_lit", 32'({salu_alu_ready, issue_violation}), 32'b10);

        // SALU: select, done three cycles later; then select+done while busy.
        salu_sel = 1'b1;
        tick("salu_a");
        check("salu_busy_lit", 32'(salu_alu_ready), 32'd0);
        tick("salu_b");
        check("salu_busy_lit", 32'(salu_alu_ready), 32'd0);
        tick("salu_c");
        check("salu_busy_lit", 32'(salu_alu_ready), 32'd0);
        salu_done = 1'b1;
        tick("salu_d");
        check("salu_done_lit", 32'(salu_alu_ready), 32'd1);
        salu_sel = 1'b1;
        tick("salu_e");
        salu_sel = 1'b1; salu_done = 1'b1;
        tick("salu_f");
        check("salu_both_lit", 32'({salu_alu_ready, issue_violation}), 32'b11);

        // Asynchronous reset between clock edges while simd0 is busy.
        do_reset();
        simd_sel[0] = 1'b1; lsu_done = 1'b1;
        tick("async_a");
        lsu_sel = 1'b1;
        tick("async_b");
        check("model_simd0_pin", 32'(simd_left[0]), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_simd0_lit", 32'(simd_rdy[0]), 32'd1);
        check("async_credit_lit", 32'(lsu_credit_cnt), 32'd4);
        check("async_viol_lit", 32'(issue_violation), 32'd0);
        check_all("async");
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic; even blocks only issue to units the model
        // says are ready, odd blocks issue freely.
        for (int blk = 0; blk < 12; blk++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                for (int i = 0; i < 4; i++) begin
                    simd_sel[i] = ($urandom_range(0, 3) == 0);
                    simf_sel[i] = ($urandom_range(0, 3) == 0);
                    if (blk % 2 == 0) begin
                        if (simd_left[i] != 0) simd_sel[i] = 1'b0;
                        if (simf_left[i] != 0) simf_sel[i] = 1'b0;
                    end
                end
                lsu_sel   = ($urandom_range(0, 2) == 0);
                lsu_done  = ($urandom_range(0, 2) == 0);
                salu_sel  = ($urandom_range(0, 3) == 0);
                salu_done = ($urandom_range(0, 2) == 0);
                if (blk % 2 == 0) begin
                    if (credits == 0 && !lsu_done) lsu_sel = 1'b0;
                    if (credits == CRED_N && !lsu_sel) lsu_done = 1'b0;
                    if (salu_busy_m) salu_sel = 1'b0;
                end
                tick("rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_busy_tracker.md
ALU_BUSY_TRACKER -- requirements
Module: alu_busy_tracker

Interface
REQ-001 SHALL have parameter SIMD_BUSY_CYCLES, default 4: cycles a SIMD ALU stays busy after selection (legal 1..15).
REQ-002 SHALL have parameter SIMF_BUSY_CYCLES, default 8: cycles a SIMF ALU stays busy after selection (legal 1..15).
REQ-003 SHALL have parameter LSU_CREDITS, default 4: LSU outstanding-issue capacity (legal 1..7).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports simd0..3_alu_select  input  1 each  issue pulse to that SIMD ALU.
REQ-007 SHALL have ports simf0..3_alu_select  input  1 each  issue pulse to that SIMF ALU.
REQ-008 SHALL have port lsu_lsu_select  input  1  issue pulse to LSU, consumes one credit.
REQ-009 SHALL have port lsu_done  input  1  LSU retired one instruction, returns one credit.
REQ-010 SHALL have port salu_alu_select  input  1  issue pulse to SALU.
REQ-011 SHALL have port salu_done  input  1  SALU finished its instruction.
REQ-012 SHALL have ports simd0..3_alu_ready, simf0..3_alu_ready  output  1 each  unit can accept issue this cycle.
REQ-013 SHALL have ports lsu_ready, salu_alu_ready  output  1 each  unit can accept issue this cycle.
REQ-014 SHALL have port lsu_credit_cnt  output  3  current free LSU credits.
REQ-015 SHALL have port issue_violation  output  1  sticky: select to a non-ready unit or credit overflow seen.

Function
REQ-016 Each SIMD/SIMF ALU SHALL own a 4-bit down-counter; ready = (counter == 0), driven combinationally from the register only.
REQ-017 On a select with counter == 0, counter SHALL load SIMD_BUSY_CYCLES / SIMF_BUSY_CYCLES at that edge; ready low for exactly that many following cycles.
REQ-018 Counter SHALL decrement by 1 per cycle while non-zero and SHALL saturate at 0.
REQ-019 Select on a unit whose counter is non-zero SHALL set issue_violation and SHALL NOT reload the counter.
REQ-020 Simultaneous selects to different units in one cycle SHALL all be accepted independently.
REQ-021 LSU credit counter SHALL reset to LSU_CREDITS; lsu_ready = (lsu_credit_cnt != 0).
REQ-022 lsu_lsu_select alone SHALL decrement credits; lsu_done alone SHALL increment; both together SHALL leave credits unchanged.
REQ-023 lsu_lsu_select at credits == 0 without lsu_done SHALL set issue_violation, credits stay 0.
REQ-024 lsu_done at credits == LSU_CREDITS without select SHALL set issue_violation, credits stay LSU_CREDITS.
REQ-025 SALU SHALL be a two-state FSM IDLE/BUSY: IDLE->BUSY on salu_alu_select; BUSY->IDLE on salu_done; salu_alu_ready = (state == IDLE).
REQ-026 salu_done in IDLE SHALL be ignored; salu_alu_select in BUSY SHALL set issue_violation and keep BUSY.
REQ-027 salu_alu_select and salu_done in the same BUSY cycle SHALL give IDLE (done wins, select flagged).
REQ-028 issue_violation SHALL remain 1 until reset.

Reset
REQ-029 While rst is low: all ALU counters 0, all *_ready outputs 1, lsu_credit_cnt = LSU_CREDITS, SALU IDLE, issue_violation 0.
REQ-030 Reset asserted mid-operation SHALL clear in-flight busy state immediately, asynchronously, regardless of clk.

Structure
REQ-031 Busy-cycle and credit defaults and counter widths SHALL be constants in the shared issue package.
REQ-032 The per-ALU counter SHALL be one sub-module, alu_busy_counter, instantiated 8 times with the busy-cycle value as parameter.

Verification
REQ-033 Reset release, no stimulus -> all ready 1, lsu_credit_cnt 4, issue_violation 0.
REQ-034 simd2_alu_select pulse at cycle 10 -> simd2_alu_ready 0 in cycles 11..14, 1 at 15; other readies stay 1.
REQ-035 simf0_alu_select at cycle 5, again at cycle 7 -> issue_violation 1 from cycle 8, simf0 ready returns at cycle 14.
REQ-036 Five lsu_lsu_select pulses, no done -> credits 3,2,1,0, lsu_ready 0, fifth sets issue_violation; select+done together at 0 -> credits stay 0, no new violation.
REQ-037 salu_alu_select, salu_done 3 cycles later -> salu_alu_ready 0 for 3 cycles then 1; select+done same BUSY cycle -> IDLE, violation 1.
REQ-038 rst low while simd0 busy with counter 3 -> simd0_alu_ready 1 immediately without clock edge.
